// File: rtl/wb2uart.sv
// Wishbone slave that forwards each bus cycle to a remote uart2wb bridge as an
// ASCII command stream, checking every reply byte and ending with ack or err.
module wb2uart #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [23:0] i_wb_adr,
    input  logic [7:0]  i_wb_dat,
    output logic [7:0]  o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [7:0]  o_tx_dat,
    output logic        o_send,
    input  logic        i_tx_busy,
    input  logic [7:0]  i_rx_dat,
    input  logic        i_received
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CH_P   = 8'h70;
    localparam logic [7:0] CH_W   = 8'h77;
    localparam logic [7:0] CH_R   = 8'h72;
    localparam logic [7:0] CH_DOT = 8'h2E;
    localparam logic [7:0] CH_K   = 8'h6B;

    typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, READ_NIB, ABORT, DONE} state_t;
    typedef enum logic [1:0] {PH_ADDR, PH_WRITE, PH_READ} phase_t;

    state_t        state;
    phase_t        phase;
    logic          cmd_stage;
    logic [2:0]    nib;
    logic [23:0]   adr_q;
    logic [7:0]    dat_q;
    logic          we_q;
    logic          live;
    logic [23:0]   cache_adr;
    logic          cache_vld;
    logic [7:0]    tx_byte;
    logic [7:0]    exp_byte;
    logic [TW-1:0] timer;
    logic [3:0]    rd_lo;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic hex_ok(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : (c[3:0] + 4'd9);
    endfunction

    function automatic logic [3:0] adr_nib(input logic [23:0] a, input logic [2:0] idx);
        logic [3:0] r;
        case (idx)
            3'd0:    r = a[3:0];
            3'd1:    r = a[7:4];
            3'd2:    r = a[11:8];
            3'd3:    r = a[15:12];
            3'd4:    r = a[19:16];
            3'd5:    r = a[23:20];
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            state     <= IDLE;
            phase     <= PH_ADDR;
            cmd_stage <= 1'b0;
            nib       <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            live      <= 1'b0;
            cache_adr <= '0;
            cache_vld <= 1'b0;
            tx_byte   <= '0;
            exp_byte  <= '0;
            timer     <= '0;
            rd_lo     <= '0;
            o_wb_dat  <= '0;
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_tx_dat  <= '0;
            o_send    <= 1'b0;
        end else begin
            o_send   <= 1'b0;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            // Once cyc drops mid-transaction the UART sequence still runs, but no ack/err is given.
            if (state != IDLE)
                live <= live & i_wb_cyc;

            case (state)
                IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        adr_q     <= i_wb_adr;
                        dat_q     <= i_wb_dat;
                        we_q      <= i_wb_we;
                        live      <= 1'b1;
                        cmd_stage <= 1'b1;
                        nib       <= '0;
                        state     <= SEND;
                        if (cache_vld && (cache_adr == i_wb_adr)) begin
                            phase    <= i_wb_we ? PH_WRITE : PH_READ;
                            tx_byte  <= i_wb_we ? CH_W : CH_R;
                            exp_byte <= i_wb_we ? CH_W : CH_R;
                        end else begin
                            phase    <= PH_ADDR;
                            tx_byte  <= CH_P;
                            exp_byte <= CH_P;
                        end
                    end
                end

                SEND: begin
                    if (!i_tx_busy) begin
                        o_send   <= 1'b1;
                        o_tx_dat <= tx_byte;
                        timer    <= '0;
                        state    <= WAIT_RESP;
                    end
                end

                WAIT_RESP: begin
                    if (i_received) begin
                        if (i_rx_dat != exp_byte) begin
                            state <= ABORT;
                        end else begin
                            case (phase)
                                PH_ADDR: begin
                                    if (cmd_stage) begin
                                        cmd_stage <= 1'b0;
                                        nib       <= '0;
                                        tx_byte   <= hex_char(adr_nib(adr_q, 3'd0));
                                        exp_byte  <= CH_K;
                                        state     <= SEND;
                                    end else if (nib == 3'd5) begin
                                        cache_adr <= adr_q;
                                        cache_vld <= 1'b1;
                                        phase     <= we_q ? PH_WRITE : PH_READ;
                                        cmd_stage <= 1'b1;
                                        tx_byte   <= we_q ? CH_W : CH_R;
                                        exp_byte  <= we_q ? CH_W : CH_R;
                                        state     <= SEND;
                                    end else begin
                                        nib     <= nib + 3'd1;
                                        tx_byte <= hex_char(adr_nib(adr_q, nib + 3'd1));
                                        state   <= SEND;
                                    end
                                end
                                PH_WRITE: begin
                                    if (cmd_stage) begin
                                        cmd_stage <= 1'b0;
                                        nib       <= '0;
                                        tx_byte   <= hex_char(dat_q[3:0]);
                                        exp_byte  <= CH_K;
                                        state     <= SEND;
                                    end else if (nib == 3'd1) begin
                                        o_wb_ack <= live & i_wb_cyc;
                                        state    <= DONE;
                                    end else begin
                                        nib     <= 3'd1;
                                        tx_byte <= hex_char(dat_q[7:4]);
                                        state   <= SEND;
                                    end
                                end
                                default: begin
                                    cmd_stage <= 1'b0;
                                    nib       <= '0;
                                    timer     <= '0;
                                    state     <= READ_NIB;
                                end
                            endcase
                        end
                    end else if (timer == TLIM) begin
                        state <= ABORT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                READ_NIB: begin
                    if (i_received) begin
                        if (!hex_ok(i_rx_dat)) begin
                            state <= ABORT;
                        end else if (nib == 3'd0) begin
                            rd_lo <= hex_val(i_rx_dat);
                            nib   <= 3'd1;
                            timer <= '0;
                        end else begin
                            o_wb_dat <= {hex_val(i_rx_dat), rd_lo};
                            o_wb_ack <= live & i_wb_cyc;
                            state    <= DONE;
                        end
                    end else if (timer == TLIM) begin
                        state <= ABORT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ABORT: begin
                    cache_vld <= 1'b0;
                    if (!i_tx_busy) begin
                        o_send   <= 1'b1;
                        o_tx_dat <= CH_DOT;
                        o_wb_err <= live & i_wb_cyc;
                        state    <= DONE;
                    end
                end

                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb2uart.sv
// Directed bench for wb2uart: plays the remote bridge byte by byte and checks
// the transmitted command stream and bus completion against hand-derived values.
module tb_wb2uart;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [23:0] adr;
    logic [7:0]  wdat;
    logic [7:0]  rdat;
    logic        ack, err;
    logic [7:0]  tx_dat;
    logic        send;
    logic        busy;
    logic [7:0]  rx_dat;
    logic        received;

    int vectors = 0;
    int miscompares = 0;
    int send_cnt = 0, ack_cnt = 0, err_cnt = 0, both_cnt = 0;
    int last_lat = 0;
    int s0, a0, e0;
    logic [7:0] b;

    wb2uart #(.TIMEOUT_CYCLES(50)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_adr   (adr),
        .i_wb_dat   (wdat),
        .o_wb_dat   (rdat),
        .o_wb_ack   (ack),
        .o_wb_err   (err),
        .o_tx_dat   (tx_dat),
        .o_send     (send),
        .i_tx_busy  (busy),
        .i_rx_dat   (rx_dat),
        .i_received (received)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (send) send_cnt++;
        if (ack)  ack_cnt++;
        if (err)  err_cnt++;
        if (ack && err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hx(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
    endfunction

    task automatic wait_send(output logic [7:0] byte_out);
        int lat;
        lat = 0;
        while (!send && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        last_lat = lat;
        check("send_seen", 32'(send), 32'd1);
        byte_out = tx_dat;
    endtask

    task automatic xfer(input string tag, input logic [7:0] exp, input int reply);
        logic [7:0] got;
        wait_send(got);
        check(tag, 32'(got), 32'(exp));
        if (reply >= 0) begin
            received = 1'b1;
            rx_dat   = 8'(reply);
        end
        @(negedge clk);
        received = 1'b0;
    endtask

    task automatic wait_done();
        int lat;
        lat = 0;
        while (!ack && !err && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("ack_or_err_seen", 32'(ack | err), 32'd1);
    endtask

    task automatic bus_start(input logic w, input logic [23:0] a, input logic [7:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    endtask

    task automatic bus_end();
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic addr_phase(input logic [23:0] a);
        xfer("cmd_p", 8'h70, 8'h70);
        for (int i = 0; i < 6; i++)
            xfer("adr_nib", hx(a[i*4 +: 4]), 8'h6B);
    endtask

    task automatic write_phase(input logic [7:0] d);
        xfer("cmd_w", 8'h77, 8'h77);
        xfer("dat_lo", hx(d[3:0]), 8'h6B);
        xfer("dat_hi", hx(d[7:4]), 8'h6B);
    endtask

    task automatic expect_ack(input string tag);
        wait_done();
        check({tag, "_ack"}, 32'(ack), 32'd1);
        check({tag, "_noerr"}, 32'(err), 32'd0);
        bus_end();
        @(negedge clk);
        check({tag, "_ack_pulse"}, 32'(ack), 32'd0);
    endtask

    logic [7:0] t1_tx [10] = '{8'h70, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31, 8'h77, 8'h35, 8'h41};
    logic [7:0] t1_rx [10] = '{8'h70, 8'h6B, 8'h6B, 8'h6B, 8'h6B, 8'h6B, 8'h6B, 8'h77, 8'h6B, 8'h6B};

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
        busy = 1'b0; rx_dat = '0; received = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdat", 32'(rdat), 32'd0);
        check("rst_send", 32'(send), 32'd0);
        check("rst_txdat", 32'(tx_dat), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x123456 <- 0xA5 from reset: full address phase
        s0 = send_cnt; a0 = ack_cnt; e0 = err_cnt;
        bus_start(1'b1, 24'h123456, 8'hA5);
        for (int i = 0; i < 10; i++)
            xfer("t1_tx", t1_tx[i], int'(t1_rx[i]));
        expect_ack("t1");
        repeat (3) @(negedge clk);
        check("t1_sends", 32'(send_cnt - s0), 32'd10);
        check("t1_acks", 32'(ack_cnt - a0), 32'd1);
        check("t1_errs", 32'(err_cnt - e0), 32'd0);

        // Same address again: cached, only "wF0"
        s0 = send_cnt; a0 = ack_cnt;
        bus_start(1'b1, 24'h123456, 8'h0F);
        xfer("t2_w", 8'h77, 8'h77);
        xfer("t2_lo", 8'h46, 8'h6B);
        xfer("t2_hi", 8'h30, 8'h6B);
        expect_ack("t2");
        repeat (3) @(negedge clk);
        check("t2_sends", 32'(send_cnt - s0), 32'd3);
        check("t2_acks", 32'(ack_cnt - a0), 32'd1);

        // Stray byte in IDLE, then read replying 'r','3','C'
        received = 1'b1; rx_dat = 8'h6B;
        @(negedge clk);
        received = 1'b0;
        @(negedge clk);
        s0 = send_cnt;
        bus_start(1'b0, 24'h123456, 8'h00);
        xfer("t3_r", 8'h72, 8'h72);
        received = 1'b1; rx_dat = 8'h33;
        @(negedge clk);
        received = 1'b0;
        @(negedge clk);
        received = 1'b1; rx_dat = 8'h43;
        @(negedge clk);
        received = 1'b0;
        wait_done();
        check("t3_ack", 32'(ack), 32'd1);
        check("t3_rdat", 32'(rdat), 32'hC3);
        check("t3_noerr", 32'(err), 32'd0);
        bus_end();
        repeat (3) @(negedge clk);
        check("t3_sends", 32'(send_cnt - s0), 32'd1);

        // 'n' on third address nibble -> '.', err, cache dropped
        s0 = send_cnt; a0 = ack_cnt; e0 = err_cnt;
        bus_start(1'b1, 24'h00BEEF, 8'h11);
        xfer("t4_p", 8'h70, 8'h70);
        xfer("t4_n0", 8'h46, 8'h6B);
        xfer("t4_n1", 8'h45, 8'h6B);
        xfer("t4_n2", 8'h45, 8'h6E);
        wait_send(b);
        check("t4_dot", 32'(b), 32'h2E);
        check("t4_err", 32'(err), 32'd1);
        check("t4_noack", 32'(ack), 32'd0);
        bus_end();
        @(negedge clk);
        check("t4_err_pulse", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_errs", 32'(err_cnt - e0), 32'd1);
        check("t4_acks", 32'(ack_cnt - a0), 32'd0);
        check("t4_sends", 32'(send_cnt - s0), 32'd5);
        bus_start(1'b1, 24'h00BEEF, 8'h11);
        addr_phase(24'h00BEEF);
        write_phase(8'h11);
        expect_ack("t4_retry");
        repeat (2) @(negedge clk);

        // Busy held 10 cycles, then no reply to 'w' -> timeout abort
        busy = 1'b1;
        s0 = send_cnt; e0 = err_cnt;
        bus_start(1'b1, 24'h00BEEF, 8'h22);
        repeat (10) @(negedge clk);
        check("t5_held", 32'(send_cnt - s0), 32'd0);
        busy = 1'b0;
        wait_send(b);
        check("t5_release_lat", 32'(last_lat <= 2), 32'd1);
        check("t5_w", 32'(b), 32'h77);
        @(negedge clk);
        wait_send(b);
        check("t5_timeout_window", 32'(last_lat >= 48 && last_lat <= 53), 32'd1);
        check("t5_dot", 32'(b), 32'h2E);
        check("t5_err", 32'(err), 32'd1);
        bus_end();
        repeat (3) @(negedge clk);
        check("t5_sends", 32'(send_cnt - s0), 32'd2);
        check("t5_errs", 32'(err_cnt - e0), 32'd1);

        // Abort invalidated the cache: full address phase again
        bus_start(1'b1, 24'h123456, 8'h5A);
        addr_phase(24'h123456);
        write_phase(8'h5A);
        expect_ack("t6_refill");
        repeat (2) @(negedge clk);

        // Reset during 4th address nibble
        bus_start(1'b1, 24'hABCDEF, 8'h00);
        xfer("t7_p", 8'h70, 8'h70);
        xfer("t7_n0", 8'h46, 8'h6B);
        xfer("t7_n1", 8'h45, 8'h6B);
        xfer("t7_n2", 8'h44, 8'h6B);
        wait_send(b);
        check("t7_n3", 32'(b), 32'h43);
        rst_n = 1'b0;
        bus_end();
        @(negedge clk);
        check("t7_send", 32'(send), 32'd0);
        check("t7_txdat", 32'(tx_dat), 32'd0);
        check("t7_ack", 32'(ack), 32'd0);
        check("t7_err", 32'(err), 32'd0);
        check("t7_rdat", 32'(rdat), 32'd0);
        s0 = send_cnt; a0 = ack_cnt; e0 = err_cnt;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t7_no_dot", 32'(send_cnt - s0), 32'd0);
        check("t7_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("t7_no_err", 32'(err_cnt - e0), 32'd0);
        bus_start(1'b1, 24'h123456, 8'h5A);
        addr_phase(24'h123456);
        write_phase(8'h5A);
        expect_ack("t7_after");
        repeat (2) @(negedge clk);

        check("ack_err_exclusive", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
